spgd_adc_avg: RTL

Metric-acquisition front end for the SPGD loop. It sits directly upstream of the SPGD system block and answers that block's `ADC_EN`/`ADC_DONE` handshake. On each request it waits a programmable settling time after the DAC update, then averages 2^LOG2_N raw ADC samples. The result is presented as a signed fixed-point J value on `ADC_OUT`, which drives the system's `ADC_IN`.

---
 rtl/spgd_pkg.sv | 18 +
 rtl/adc_fxp_scale.sv | 27 ++
 rtl/spgd_adc_avg.sv | 123 ++++++++++++
 3 files changed

// File: rtl/spgd_pkg.sv
// Shared types and sizing helpers for the SPGD loop blocks.
// Holds the ADC averager state encoding and accumulator width rule.
package spgd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } adc_avg_state_t;

  localparam int LOG2_N_MAX_DEF = 12;

  function automatic int acc_width(int adc_w, int log2_max);
    return adc_w + log2_max;
  endfunction

endpackage

// File: rtl/adc_fxp_scale.sv
// Converts an accumulated ADC sum into signed fixed point.
// Full-scale sample maps to +/-1.0; division by 2^l2n floors.
module adc_fxp_scale
  import spgd_pkg::*;
#(
  parameter int ACC_W = 26,
  parameter int ADC_W = 14,
  parameter int FRAC  = 16,
  parameter int FP_W  = 32
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [3:0]       l2n_i,
  output logic [FP_W-1:0]  res_o
);

  localparam int LS = FRAC - (ADC_W - 1);
  localparam int EW = ACC_W + LS + FP_W;

  logic signed [EW-1:0] ext;

  always_comb begin
    ext   = {{(EW-ACC_W){acc_i[ACC_W-1]}}, acc_i};
    // arithmetic right shift truncates toward minus infinity
    res_o = FP_W'((ext <<< LS) >>> l2n_i);
  end

endmodule

// File: rtl/spgd_adc_avg.sv
// SPGD metric front end: settle, average 2^LOG2_N samples, report J.
// Answers the ADC_EN / ADC_DONE request handshake of the SPGD FSM.
module spgd_adc_avg
  import spgd_pkg::*;
#(
  parameter int ADC_WIDTH  = 14,
  parameter int FP_WIDTH   = 32,
  parameter int INT_WIDTH  = 16,
  parameter int LOG2_N_MAX = LOG2_N_MAX_DEF
) (
  input  logic                 ADC_CLK,
  input  logic                 ADC_RST_N,
  input  logic                 ADC_EN,
  input  logic [ADC_WIDTH-1:0] ADC_RAW,
  input  logic [15:0]          SETTLE,
  input  logic [3:0]           LOG2_N,
  output logic [FP_WIDTH-1:0]  ADC_OUT,
  output logic                 ADC_DONE,
  output logic                 BUSY
);

  localparam int FRAC  = FP_WIDTH - INT_WIDTH;
  localparam int ACC_W = acc_width(ADC_WIDTH, LOG2_N_MAX);

  adc_avg_state_t       state_q;
  logic [15:0]          cnt_q;
  logic [3:0]           l2n_q;
  logic [3:0]           l2n_clamp;
  logic [ACC_W-1:0]     acc_q;
  logic [ACC_W-1:0]     acc_d;
  logic [ADC_WIDTH-1:0] raw_q;
  logic [FP_WIDTH-1:0]  out_q;
  logic [FP_WIDTH-1:0]  scaled;
  logic                 done_q;
  logic                 busy_q;

  assign l2n_clamp = (LOG2_N > 4'(LOG2_N_MAX)) ?
                     4'(LOG2_N_MAX) : LOG2_N;

  always_comb begin
    acc_d = acc_q +
      {{(ACC_W-ADC_WIDTH){raw_q[ADC_WIDTH-1]}}, raw_q};
  end

  adc_fxp_scale #(
    .ACC_W (ACC_W),
    .ADC_W (ADC_WIDTH),
    .FRAC  (FRAC),
    .FP_W  (FP_WIDTH)
  ) u_scale (
    .acc_i (acc_d),
    .l2n_i (l2n_q),
    .res_o (scaled)
  );

  always_ff @(posedge ADC_CLK or negedge ADC_RST_N) begin
    if (!ADC_RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      l2n_q   <= '0;
      acc_q   <= '0;
      raw_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      raw_q <= ADC_RAW;
      unique case (state_q)
        ST_IDLE: begin
          if (ADC_EN) begin
            l2n_q  <= l2n_clamp;
            acc_q  <= '0;
            busy_q <= 1'b1;
            if (SETTLE != 16'd0) begin
              state_q <= ST_SETTLE;
              cnt_q   <= SETTLE;
            end else begin
              state_q <= ST_ACCUM;
              cnt_q   <= 16'd1 << l2n_clamp;
            end
          end
        end
        ST_SETTLE: begin
          if (!ADC_EN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 16'd1) begin
            state_q <= ST_ACCUM;
            cnt_q   <= 16'd1 << l2n_q;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_ACCUM: begin
          if (!ADC_EN) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              out_q   <= scaled;
            end
          end
        end
        ST_DONE: begin
          if (!ADC_EN) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ADC_OUT  = out_q;
  assign ADC_DONE = done_q;
  assign BUSY     = busy_q;

endmodule
